// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into short, double and long presses,
// with periodic auto-repeat pulses while a long press is held.
module button_event_decoder #(
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned LONG_MS   = 500,
  parameter int unsigned DOUBLE_MS = 250,
  parameter int unsigned REPEAT_MS = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic long_active
);

  localparam int unsigned MS_MAX =
    (LONG_MS > DOUBLE_MS) ? ((LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS)
                          : ((DOUBLE_MS > REPEAT_MS) ? DOUBLE_MS : REPEAT_MS);
  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MS_W  = $clog2(MS_MAX + 1);

  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICK_DIV - 1);
  localparam logic [MS_W-1:0]  LONG_LAST   = MS_W'(LONG_MS - 1);
  localparam logic [MS_W-1:0]  DOUBLE_LAST = MS_W'(DOUBLE_MS - 1);
  localparam logic [MS_W-1:0]  REPEAT_LAST = MS_W'(REPEAT_MS - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    LONG_HOLD
  } state_t;

  state_t           state;
  logic             btn_prev;
  logic [PRE_W-1:0] pre_cnt;
  logic [MS_W-1:0]  ms_cnt;
  logic             rise;
  logic             fall;
  logic             tick;

  always_comb begin
    rise = btn_level & ~btn_prev;
    fall = ~btn_level & btn_prev;
    tick = (pre_cnt == PRE_LAST);
  end

  // Limits are checked as "ms counter about to reach N on this tick", so the
  // decision edge is exactly N*TICK_DIV cycles after the state was entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      btn_prev     <= 1'b1;
      pre_cnt      <= '0;
      ms_cnt       <= '0;
      short_press  <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      long_active  <= 1'b0;
    end else begin
      btn_prev     <= btn_level;
      short_press  <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;

      if (tick) begin
        pre_cnt <= '0;
        ms_cnt  <= ms_cnt + 1'b1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          pre_cnt <= '0;
          ms_cnt  <= '0;
          if (rise) state <= PRESS1;
        end
        PRESS1: begin
          if (fall) begin
            state   <= WAIT2;
            pre_cnt <= '0;
            ms_cnt  <= '0;
          end else if (btn_level && tick && ms_cnt == LONG_LAST) begin
            state       <= LONG_HOLD;
            long_press  <= 1'b1;
            long_active <= 1'b1;
            pre_cnt     <= '0;
            ms_cnt      <= '0;
          end
        end
        WAIT2: begin
          if (rise) begin
            state   <= PRESS2;
            pre_cnt <= '0;
            ms_cnt  <= '0;
          end else if (tick && ms_cnt == DOUBLE_LAST) begin
            state       <= IDLE;
            short_press <= 1'b1;
            pre_cnt     <= '0;
            ms_cnt      <= '0;
          end
        end
        PRESS2: begin
          // No limit applies here, so the timer is held clear to avoid wrap.
          pre_cnt <= '0;
          ms_cnt  <= '0;
          if (fall) begin
            state        <= IDLE;
            double_press <= 1'b1;
          end
        end
        LONG_HOLD: begin
          if (fall) begin
            state       <= IDLE;
            long_active <= 1'b0;
            pre_cnt     <= '0;
            ms_cnt      <= '0;
          end else if (tick && ms_cnt == REPEAT_LAST) begin
            repeat_pulse <= 1'b1;
            pre_cnt      <= '0;
            ms_cnt       <= '0;
          end
        end
        default: begin
          state       <= IDLE;
          long_active <= 1'b0;
          pre_cnt     <= '0;
          ms_cnt      <= '0;
        end
      endcase
    end
  end

endmodule
